gray_sched: RTL

GRAY_SCHED -- requirements
Module: gray_sched

---
 rtl/gray_sched.sv | 136 +++++++++++++
 1 files changed

// File: rtl/gray_sched.sv
// Round-robin arbiter granting a shared Gray-code counter to one requester per run.
// Runs count 0..len_q; done pulses on completion, abort pulses when the winner drops req mid-run.
module gray_sched #(
  parameter int CBITS = 8,
  parameter int NREQ  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [CBITS-1:0] len,
  output logic [NREQ-1:0]  gnt,
  output logic             busy,
  output logic [CBITS-1:0] gray_c,
  output logic             done,
  output logic             abort
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CBITS-1:0] cnt, cnt_nxt;
  logic [CBITS-1:0] len_q, len_nxt;
  logic [PW-1:0]    ptr, ptr_nxt;
  logic [PW-1:0]    winner, win_nxt;
  logic [NREQ-1:0]  gnt_nxt;
  logic             busy_nxt;
  logic [CBITS-1:0] gray_nxt;
  logic             done_nxt;
  logic             abort_nxt;

  logic             found;
  logic [PW-1:0]    win_sel;
  logic [CBITS-1:0] cnt_inc;

  assign cnt_inc = cnt + CBITS'(1);

  // Scan upward from ptr+1 so the last winner becomes lowest priority.
  always_comb begin
    found   = 1'b0;
    win_sel = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && req[(int'(ptr) + i) % NREQ]) begin
        found   = 1'b1;
        win_sel = PW'((int'(ptr) + i) % NREQ);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    len_nxt   = len_q;
    ptr_nxt   = ptr;
    win_nxt   = winner;
    gnt_nxt   = gnt;
    busy_nxt  = busy;
    gray_nxt  = gray_c;
    done_nxt  = 1'b0;
    abort_nxt = 1'b0;
    case (state)
      IDLE: begin
        gnt_nxt  = '0;
        busy_nxt = 1'b0;
        if (found) begin
          state_nxt        = RUN;
          win_nxt          = win_sel;
          len_nxt          = len;
          cnt_nxt          = '0;
          gnt_nxt[win_sel] = 1'b1;
          busy_nxt         = 1'b1;
          gray_nxt         = '0;
        end
      end
      RUN: begin
        // A dropped request wins over completion on the same edge.
        if (!req[winner]) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
          abort_nxt = 1'b1;
          ptr_nxt   = winner;
        end else if (cnt == len_q) begin
          state_nxt = DONE;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          ptr_nxt   = winner;
        end else begin
          cnt_nxt  = cnt_inc;
          gray_nxt = cnt_inc ^ (cnt_inc >> 1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      len_q  <= '0;
      ptr    <= PW'(NREQ - 1);
      winner <= '0;
      gnt    <= '0;
      busy   <= 1'b0;
      gray_c <= '0;
      done   <= 1'b0;
      abort  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      len_q  <= len_nxt;
      ptr    <= ptr_nxt;
      winner <= win_nxt;
      gnt    <= gnt_nxt;
      busy   <= busy_nxt;
      gray_c <= gray_nxt;
      done   <= done_nxt;
      abort  <= abort_nxt;
    end
  end

endmodule
